conv_row_sequencer: RTL and testbench

Control stage directly upstream of the row selector in the 28-unit convolution architecture. On `start`, it walks the output rows 0..H-F. For each row it:
- presents the F-row input window to the bank of parallel convolution units;
- fires them and waits for their completion;
- drives the finished output row with its `rowNumber` to the selector.

After the last row it drives the terminal row number H-F+1 (28 at defaults) and raises `done`.

---
 rtl/conv_row_sequencer_if.sv | 32 +++
 rtl/conv_row_sequencer.sv | 104 ++++++++++
 tb/tb_conv_row_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_row_sequencer_if.sv
// Handshake and data bus between the row sequencer, the image source,
// the parallel convolution units and the downstream row selector.
interface conv_row_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
);
  localparam int OW = W - F + 1;

  logic                           start;
  logic [0:H*W*DATA_WIDTH-1]      image;
  logic [0:F*W*DATA_WIDTH-1]      window;
  logic                           convStart;
  logic [0:OW*DATA_WIDTH-1]       convRow;
  logic                           convDone;
  logic [0:OW*DATA_WIDTH-1]       row;
  logic [5:0]                     rowNumber;
  logic                           rowValid;
  logic                           busy;
  logic                           done;

  modport master (
    output start, image, convRow, convDone,
    input  window, convStart, row, rowNumber, rowValid, busy, done
  );

  modport slave (
    input  start, image, convRow, convDone,
    output window, convStart, row, rowNumber, rowValid, busy, done
  );
endinterface

// File: rtl/conv_row_sequencer.sv
// Walks output rows 0..H-F: loads the F-row window, fires the conv units,
// waits for completion and hands the captured row to the selector.
module conv_row_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_row_sequencer_if.slave    bus
);
  localparam int OW       = W - F + 1;
  localparam int ROW_BITS = W * DATA_WIDTH;
  localparam int WIN_BITS = F * ROW_BITS;
  localparam int AW       = $clog2(H * ROW_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_CAPTURE, S_FINISH
  } state_e;

  state_e                       state_q, state_d;
  logic [5:0]                   r_q, r_d;
  logic [0:WIN_BITS-1]          window_q, window_d;
  logic [0:OW*DATA_WIDTH-1]     row_q, row_d;
  logic [5:0]                   rownum_q, rownum_d;
  logic                         convstart_q, convstart_d;
  logic                         rowvalid_q, rowvalid_d;
  logic [AW-1:0]                base;

  assign base = AW'(r_q) * AW'(ROW_BITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      window_q    <= '0;
      row_q       <= '0;
      rownum_q    <= '0;
      convstart_q <= 1'b0;
      rowvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      window_q    <= window_d;
      row_q       <= row_d;
      rownum_q    <= rownum_d;
      convstart_q <= convstart_d;
      rowvalid_q  <= rowvalid_d;
    end
  end

  // Pulses are set on the edge entering FIRE / CAPTURE so they are
  // registered and last exactly the one cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    window_d    = window_q;
    row_d       = row_q;
    rownum_d    = rownum_q;
    convstart_d = 1'b0;
    rowvalid_d  = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (bus.start) begin
          state_d = S_LOAD;
          r_d     = '0;
        end
      end
      S_LOAD: begin
        window_d    = bus.image[base +: WIN_BITS];
        convstart_d = 1'b1;
        state_d     = S_FIRE;
      end
      S_FIRE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.convDone) begin
          row_d      = bus.convRow;
          rownum_d   = r_q;
          rowvalid_d = 1'b1;
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (r_q == 6'(H - F)) begin
          rownum_d = 6'(H - F + 1);
          state_d  = S_FINISH;
        end else begin
          r_d     = r_q + 6'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.window    = window_q;
  assign bus.convStart = convstart_q;
  assign bus.row       = row_q;
  assign bus.rowNumber = rownum_q;
  assign bus.rowValid  = rowvalid_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign bus.done      = (state_q == S_FINISH);
endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed bench for conv_row_sequencer: a conv-unit responder with per-row
// latency, a rowValid recorder, and one task per scenario.
module tb_conv_row_sequencer;
  localparam int DW = 32, H = 32, W = 32, F = 5;
  localparam int OW = W - F + 1;
  localparam int NR = H - F + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_row_sequencer_if #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) bus();

  conv_row_sequencer #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Conv units echo the first window word plus the column index.
  always_comb begin
    bus.convRow = '0;
    for (int j = 0; j < OW; j++)
      bus.convRow[j*DW +: DW] = bus.window[0 +: DW] + DW'(j);
  end

  // Responder: convDone goes high `lat[row]` cycles into WAIT; with spur set
  // it is also held high whenever no conversion is pending.
  int lat [0:NR-1];
  bit spur;
  bit active = 1'b0;
  int cd = 0;
  int fired = 0;
  always @(negedge clk) begin
    if (bus.convStart === 1'b1) begin
      fired++;
      active = 1'b1;
      cd = lat[int'(bus.window[0 +: DW]) / W];
      bus.convDone = spur;
    end else if (active) begin
      if (cd == 0) begin
        bus.convDone = 1'b1;
        active = 1'b0;
      end else begin
        cd--;
        bus.convDone = 1'b0;
      end
    end else begin
      bus.convDone = spur;
    end
  end

  int rec_cyc[$];
  int rec_num[$];
  logic [DW-1:0] rec_w0[$], rec_wl[$], rec_win[$];
  always @(negedge clk) begin
    if (bus.rowValid === 1'b1) begin
      rec_cyc.push_back(cyc);
      rec_num.push_back(int'(bus.rowNumber));
      rec_w0.push_back(bus.row[0 +: DW]);
      rec_wl.push_back(bus.row[(OW-1)*DW +: DW]);
      rec_win.push_back(bus.window[0 +: DW]);
    end
  end

  // s = cycle index while the DUT sits in LOAD after accepting start
  task automatic start_frame(output int s);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        c = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_chk++; if (bus.rowNumber !== 6'd0) $display("FAIL reset_rownum got %0d want 0", bus.rowNumber); else n_pass++;
    n_chk++; if ({bus.convStart, bus.rowValid} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {bus.convStart, bus.rowValid}); else n_pass++;
    n_chk++; if ((|bus.window) !== 1'b0 || (|bus.row) !== 1'b0) $display("FAIL reset_data got nonzero window/row want 0"); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_full_frame;
    int s, c, base, fbase;
    bit ok;
    base = rec_num.size();
    fbase = fired;
    start_frame(s);
    wait_done(300, c, ok);
    n_chk++; if (!ok) $display("FAIL full_timeout got no done want done"); else n_pass++;
    n_chk++; if (c - s != 112) $display("FAIL full_done_cycle got %0d want 113", c - s + 1); else n_pass++;
    n_chk++; if (bus.rowNumber !== 6'd28) $display("FAIL full_term_rownum got %0d want 28", bus.rowNumber); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL full_busy_finish got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (rec_num.size() - base != NR) $display("FAIL full_rows got %0d want %0d", rec_num.size() - base, NR); else n_pass++;
    n_chk++; if (fired - fbase != NR) $display("FAIL full_convstarts got %0d want %0d", fired - fbase, NR); else n_pass++;
    if (rec_num.size() - base == NR) begin
      for (int r = 0; r < NR; r++) begin
        n_chk++; if (rec_num[base+r] != r) $display("FAIL full_rownum[%0d] got %0d want %0d", r, rec_num[base+r], r); else n_pass++;
        n_chk++; if (rec_cyc[base+r] - s != 3 + 4*r) $display("FAIL full_cycle[%0d] got %0d want %0d", r, rec_cyc[base+r] - s + 1, 4 + 4*r); else n_pass++;
        n_chk++; if (rec_win[base+r] !== DW'(r*W)) $display("FAIL full_window[%0d] got %0d want %0d", r, rec_win[base+r], r*W); else n_pass++;
        n_chk++; if (rec_w0[base+r] !== DW'(r*W) || rec_wl[base+r] !== DW'(r*W + OW - 1))
          $display("FAIL full_row[%0d] got %0d..%0d want %0d..%0d", r, rec_w0[base+r], rec_wl[base+r], r*W, r*W + OW - 1); else n_pass++;
      end
    end
  endtask

  // Restart from FINISH; this frame also carries the row-10 stretch.
  int rs_s, rs_base, rs_fbase;
  task automatic test_restart;
    int c, k;
    bit ok;
    lat[10] = 7;
    rs_base = rec_num.size();
    rs_fbase = fired;
    start_frame(rs_s);
    n_chk++; if (bus.done !== 1'b0) $display("FAIL restart_done got %b want 0", bus.done); else n_pass++;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL restart_busy got %b want 1", bus.busy); else n_pass++;
    k = 0;
    while (rec_num.size() == rs_base && k < 20) begin @(negedge clk); k++; end
    n_chk++; if (rec_num.size() == rs_base || rec_num[rs_base] != 0)
      $display("FAIL restart_first_row got %0d rows want rowNumber 0", rec_num.size() - rs_base); else n_pass++;
    while (cyc < rs_s + 48) @(negedge clk);
    n_chk++; if (bus.rowNumber !== 6'd9 || bus.row[0 +: DW] !== DW'(9*W))
      $display("FAIL stretch_hold got %0d/%0d want 9/%0d", bus.rowNumber, bus.row[0 +: DW], 9*W); else n_pass++;
    wait_done(300, c, ok);
    n_chk++; if (!ok || c - rs_s != 119) $display("FAIL stretch_done_cycle got %0d want 120", c - rs_s + 1); else n_pass++;
    lat[10] = 0;
  endtask

  task automatic test_stretched;
    int exp;
    n_chk++; if (fired - rs_fbase != NR) $display("FAIL stretch_convstarts got %0d want %0d", fired - rs_fbase, NR); else n_pass++;
    n_chk++; if (rec_num.size() - rs_base != NR) $display("FAIL stretch_rows got %0d want %0d", rec_num.size() - rs_base, NR); else n_pass++;
    if (rec_num.size() - rs_base == NR) begin
      for (int r = 8; r < 13; r++) begin
        exp = 3 + 4*r + ((r >= 10) ? 7 : 0);
        n_chk++; if (rec_cyc[rs_base+r] - rs_s != exp || rec_num[rs_base+r] != r)
          $display("FAIL stretch_row[%0d] got cyc %0d num %0d want cyc %0d num %0d", r, rec_cyc[rs_base+r] - rs_s + 1, rec_num[rs_base+r], exp + 1, r); else n_pass++;
      end
    end
  endtask

  task automatic test_spurious;
    int s, c, k, base, fbase;
    bit ok;
    for (int i = 0; i < NR; i++) lat[i] = 3;
    spur = 1'b1;
    base = rec_num.size();
    fbase = fired;
    start_frame(s);
    k = 0;
    while (rec_num.size() < base + 3 && k < 60) begin @(negedge clk); k++; end
    bus.start = 1'b1;
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    wait_done(400, c, ok);
    n_chk++; if (!ok || c - s != 196) $display("FAIL spur_done_cycle got %0d want 197", c - s + 1); else n_pass++;
    n_chk++; if (rec_num.size() - base != NR) $display("FAIL spur_rows got %0d want %0d", rec_num.size() - base, NR); else n_pass++;
    n_chk++; if (fired - fbase != NR) $display("FAIL spur_convstarts got %0d want %0d", fired - fbase, NR); else n_pass++;
    if (rec_num.size() - base == NR) begin
      for (int r = 0; r < NR; r++) begin
        n_chk++; if (rec_num[base+r] != r || rec_cyc[base+r] - s != 6 + 7*r)
          $display("FAIL spur_row[%0d] got num %0d cyc %0d want num %0d cyc %0d", r, rec_num[base+r], rec_cyc[base+r] - s + 1, r, 7 + 7*r); else n_pass++;
      end
    end
    spur = 1'b0;
    for (int i = 0; i < NR; i++) lat[i] = 0;
  endtask

  task automatic test_reset_mid;
    int s, k, fbase, nrec;
    lat[5] = 10;
    fbase = fired;
    start_frame(s);
    k = 0;
    while (fired < fbase + 6 && k < 60) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1 || bus.rowNumber !== 6'd4)
      $display("FAIL midreset_pre got busy %b num %0d want busy 1 num 4", bus.busy, bus.rowNumber); else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_chk++; if ({bus.busy, bus.done, bus.convStart, bus.rowValid} !== 4'b0000)
      $display("FAIL midreset_ctrl got %b want 0000", {bus.busy, bus.done, bus.convStart, bus.rowValid}); else n_pass++;
    n_chk++; if (bus.rowNumber !== 6'd0 || (|bus.row) !== 1'b0 || (|bus.window) !== 1'b0)
      $display("FAIL midreset_data got num %0d want 0 with zero row/window", bus.rowNumber); else n_pass++;
    nrec = rec_num.size();
    repeat (15) @(negedge clk);
    n_chk++; if (rec_num.size() != nrec || bus.busy !== 1'b0)
      $display("FAIL midreset_late_done got %0d extra rows busy %b want 0 rows busy 0", rec_num.size() - nrec, bus.busy); else n_pass++;
    lat[5] = 0;
  endtask

  task automatic test_reset_start;
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rststart_busy got %b want 0", bus.busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL rststart_idle got busy %b done %b want 0 0", bus.busy, bus.done); else n_pass++;
  endtask

  initial begin
    spur = 1'b0;
    for (int i = 0; i < NR; i++) lat[i] = 0;
    bus.image = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        bus.image[(i*W+j)*DW +: DW] = DW'(i*W + j);
    test_reset;
    test_full_frame;
    test_restart;
    test_stretched;
    test_spurious;
    test_reset_mid;
    test_reset_start;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
